// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART receiver.
//   - parity mode codes carried on the par input
//   - receiver FSM state encoding
//   - bit positions inside the 3-bit per-word error status
//   - 3-sample majority helper used for bit decisions
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int ERR_PAR   = 2;
    localparam int ERR_FRAME = 1;
    localparam int ERR_OVR   = 0;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO holding received words.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   push, wdata     write request and word
//   pop             read request; head advances on the next edge
//   rdata           head word, read combinationally at the registered read pointer
//   full, empty     occupancy flags
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver on an OVERSAMPLE x baud clock.
// Ports:
//   clk_rx       oversampling clock
//   reset_n      asynchronous active-low reset
//   rx           serial line, idle high, asynchronous
//   d_num        data bits per frame (clamped to 5..MAX_DATA_BITS)
//   par          parity mode: 0/3 none, 1 odd, 2 even
//   s_num        stop bits: 0 one, 1 two
//   dout, err    head-of-FIFO word and {parity_err, frame_err, overrun}
//   dout_valid   FIFO non-empty
//   dout_ready   consumer accepts the head word
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk_rx,
    input  logic                     reset_n,
    input  logic                     rx,
    input  logic [3:0]               d_num,
    input  logic [1:0]               par,
    input  logic                     s_num,
    output logic [MAX_DATA_BITS-1:0] dout,
    output logic [2:0]               err,
    output logic                     dout_valid,
    input  logic                     dout_ready
);
    localparam int             CW       = $clog2(OVERSAMPLE);
    localparam int             FW       = MAX_DATA_BITS + 3;
    localparam logic [CW-1:0]  HALF_M1  = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0]  FULL_M1  = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]     MIN_BITS = 4'd5;
    localparam logic [3:0]     MAX_BITS = 4'(MAX_DATA_BITS);

    // Two-stage synchroniser; stage 1 is the line-side input.
    logic [1:0] sync_q;
    logic       rx_s;
    logic [2:0] hist_q;
    logic       vote;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk_rx or negedge reset_n) begin
                if (!reset_n) sync_q[gi] <= 1'b1;
                else          sync_q[gi] <= (gi == 0) ? rx : sync_q[(gi == 0) ? 0 : gi-1];
            end
        end
    endgenerate

    assign rx_s = sync_q[1];
    assign vote = majority3(hist_q);

    rx_state_t               state_q,   state_d;
    logic [CW-1:0]           cnt_q,     cnt_d;
    logic [3:0]              bit_idx_q, bit_idx_d;
    logic [MAX_DATA_BITS-1:0] shreg_q,  shreg_d;
    logic [3:0]              dbits_q,   dbits_d;
    logic [1:0]              par_q,     par_d;
    logic                    stop2_q,   stop2_d;
    logic                    perr_q,    perr_d;
    logic                    ferr_q,    ferr_d;
    logic                    ovr_q,     ovr_d;
    logic [FW-1:0]           hold_q,    hold_d;

    logic          eof;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0] fifo_head, fifo_wdata;

    assign fifo_pop   = !fifo_empty && dout_ready;
    assign fifo_push  = eof && (!fifo_full || fifo_pop);
    // ferr_d already includes the verdict of the stop sample taken this cycle.
    assign fifo_wdata = {shreg_q, perr_q, ferr_d, ovr_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        dbits_d   = dbits_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        eof       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s && hist_q[0]) begin
                    state_d   = ST_START;
                    dbits_d   = (d_num < MIN_BITS) ? MIN_BITS :
                                (d_num > MAX_BITS) ? MAX_BITS : d_num;
                    par_d     = par;
                    stop2_d   = s_num;
                    shreg_d   = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    // A high vote at mid-start means the edge was a glitch.
                    state_d   = vote ? ST_IDLE : ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    for (int i = 0; i < MAX_DATA_BITS; i++) begin
                        if (bit_idx_q == 4'(i)) shreg_d[i] = vote;
                    end
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == dbits_q - 4'd1) begin
                        state_d = (par_q == PAR_ODD || par_q == PAR_EVEN) ? ST_PARITY : ST_STOP1;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    // Bits above the frame width are zero, so XOR of the whole register is the data XOR.
                    if (vote != ((^shreg_q) ^ (par_q == PAR_ODD))) perr_d = 1'b1;
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1, ST_STOP2: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (!vote) ferr_d = 1'b1;
                    if (state_q == ST_STOP1 && stop2_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        eof     = 1'b1;
                        state_d = vote ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ovr_d = ovr_q;
        if (eof) ovr_d = !fifo_push;
        hold_d = hold_q;
        if (fifo_pop) hold_d = fifo_head;
    end

    always_ff @(posedge clk_rx or negedge reset_n) begin
        if (!reset_n) begin
            hist_q    <= 3'b111;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            dbits_q   <= MIN_BITS;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            hist_q    <= {hist_q[1:0], rx_s};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            dbits_q   <= dbits_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            hold_q    <= hold_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_rx),
        .rst_n (reset_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // When empty, present the last word handed out (zero after reset).
    assign dout       = fifo_empty ? hold_q[FW-1:3] : fifo_head[FW-1:3];
    assign err        = fifo_empty ? hold_q[2:0]    : fifo_head[2:0];
    assign dout_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param.
// Expected {dout, err} words are queued when a frame is driven and compared
// by a monitor whenever the DUT hands a word over.
module tb_uart_rx_param;

    logic       clk_rx = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [3:0] d_num;
    logic [1:0] par;
    logic       s_num;
    logic [8:0] dout;
    logic [2:0] err;
    logic       dout_valid;
    logic       dout_ready;

    int errors = 0;
    int checks = 0;

    logic [11:0] sb_q [$];
    logic [11:0] mon_exp;

    always #5 clk_rx = ~clk_rx;

    uart_rx_param #(
        .OVERSAMPLE    (16),
        .MAX_DATA_BITS (9),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk_rx     (clk_rx),
        .reset_n    (reset_n),
        .rx         (rx),
        .d_num      (d_num),
        .par        (par),
        .s_num      (s_num),
        .dout       (dout),
        .err        (err),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; leaves on the falling edge that ends the bit.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk_rx);
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                              input bit par_bit, input int nstop, input bit stop_val,
                              input int tail_low);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(data[i]);
        if (has_par) drive_bit(par_bit);
        for (int i = 0; i < nstop; i++) drive_bit(stop_val);
        repeat (tail_low) @(negedge clk_rx);
        rx = 1'b1;
        repeat (24) @(negedge clk_rx);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk_rx);
            n++;
        end
        check_val(tag, sb_q.size(), 0);
    endtask

    always @(negedge clk_rx) begin
        if (reset_n && dout_valid && dout_ready) begin
            if (sb_q.size() == 0) begin
                $display("word dout=%03h err=%03b (none expected)", dout, err);
                check_val("spurious_word", {20'd0, dout, err}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = sb_q.pop_front();
                $display("word dout=%03h err=%03b expect dout=%03h err=%03b",
                         dout, err, mon_exp[11:3], mon_exp[2:0]);
                check_val("word", {20'd0, dout, err}, {20'd0, mon_exp});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_n    = 1'b0;
        rx         = 1'b1;
        d_num      = 4'd8;
        par        = 2'd0;
        s_num      = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk_rx);
        check_val("rst_valid", dout_valid, 0);
        check_val("rst_dout", dout, 0);
        check_val("rst_err", err, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_rx);

        // 8N1 0xA5 with latency from start edge to dout_valid
        sb_q.push_back({9'h0A5, 3'b000});
        fork
            send_frame(9'h0A5, 8, 0, 0, 1, 1, 0);
            begin
                lat = 0;
                while (!dout_valid && lat < 400) begin
                    @(negedge clk_rx);
                    lat++;
                end
                check_val("lat_8n1", lat, 155);
                @(negedge clk_rx);
                check_val("valid_pulse", dout_valid, 0);
            end
        join
        wait_drain("drain_8n1");

        // 7 bits, odd parity, two stop bits
        d_num = 4'd7; par = 2'd1; s_num = 1'b1;
        sb_q.push_back({9'h041, 3'b000});
        send_frame(9'h041, 7, 1, 1, 2, 1, 0);
        sb_q.push_back({9'h041, 3'b100});
        send_frame(9'h041, 7, 1, 0, 2, 1, 0);
        wait_drain("drain_7o2");

        // 9N1 with a low stop bit and the line held low afterwards
        d_num = 4'd9; par = 2'd0; s_num = 1'b0;
        sb_q.push_back({9'h1C3, 3'b010});
        send_frame(9'h1C3, 9, 0, 0, 1, 0, 40);
        wait_drain("drain_break");
        sb_q.push_back({9'h055, 3'b000});
        send_frame(9'h055, 9, 0, 0, 1, 1, 0);
        wait_drain("drain_after_break");

        // 4-tick glitch must be ignored, then a clean frame still works
        rx = 1'b0;
        repeat (4) @(negedge clk_rx);
        rx = 1'b1;
        repeat (40) @(negedge clk_rx);
        check_val("glitch_valid", dout_valid, 0);
        sb_q.push_back({9'h0AA, 3'b000});
        send_frame(9'h0AA, 9, 0, 0, 1, 1, 0);
        wait_drain("drain_glitch");

        // d_num clamping at both ends
        d_num = 4'd2;
        sb_q.push_back({9'h015, 3'b000});
        send_frame(9'h015, 5, 0, 0, 1, 1, 0);
        d_num = 4'd15;
        sb_q.push_back({9'h1F0, 3'b000});
        send_frame(9'h1F0, 9, 0, 0, 1, 1, 0);
        wait_drain("drain_clamp");

        // Overrun: five frames into a four-entry FIFO with no consumer
        d_num = 4'd8;
        dout_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            if (v <= 4) sb_q.push_back({9'(v), 3'b000});
            send_frame(9'(v), 8, 0, 0, 1, 1, 0);
        end
        check_val("ovr_valid", dout_valid, 1);
        check_val("ovr_head", {dout, err}, {9'h001, 3'b000});
        repeat (10) @(negedge clk_rx);
        check_val("ovr_stable", {dout, err}, {9'h001, 3'b000});
        @(posedge clk_rx);
        #1 dout_ready = 1'b1;
        @(negedge clk_rx);
        wait_drain("drain_ovr");
        sb_q.push_back({9'h006, 3'b001});
        send_frame(9'h006, 8, 0, 0, 1, 1, 0);
        wait_drain("drain_ovr_flag");
        check_val("hold_dout", {dout, err}, {9'h006, 3'b001});
        check_val("hold_valid", dout_valid, 0);

        // Reset during the 4th data bit of 0x3C
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'((9'h03C >> i) & 9'h1));
        rx = 1'b1;
        repeat (8) @(negedge clk_rx);
        reset_n = 1'b0;
        repeat (4) @(negedge clk_rx);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_rx);
        check_val("mid_rst_valid", dout_valid, 0);
        check_val("mid_rst_err", err, 0);
        check_val("mid_rst_dout", dout, 0);
        repeat (200) @(negedge clk_rx);
        check_val("mid_rst_quiet", dout_valid, 0);
        sb_q.push_back({9'h03C, 3'b000});
        send_frame(9'h03C, 8, 0, 0, 1, 1, 0);
        wait_drain("drain_after_rst");

        repeat (20) @(negedge clk_rx);
        check_val("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
